// File: rtl/tea_stream_pkg.sv
// Shared definitions for the TEA plaintext stream generator.
//   LFSR_POLY  - feedback mask of the 64-bit right-shift Galois LFSR
//   state_t    - 2-bit encoding of the generator FSM states
//   lfsr_next  - one LFSR step
package tea_stream_pkg;

    localparam logic [63:0] LFSR_POLY = 64'hD800000000000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAPW = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    function automatic logic [63:0] lfsr_next(input logic [63:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 64'h0);
    endfunction

endpackage

// File: rtl/tea_stream_gen_lfsr64.sv
// 64-bit Galois LFSR holding the plaintext sequence state.
//   clk, resetn : clock, asynchronous active-low reset (state clears to 0)
//   load, seed  : load seed (takes priority over step)
//   step        : advance one position
//   q           : current sequence value
module lfsr64
    import tea_stream_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        load,
    input  logic [63:0] seed,
    input  logic        step,
    output logic [63:0] q
);

    logic [63:0] r_state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= 64'h0;
        end else if (load) begin
            r_state <= seed;
        end else if (step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign q = r_state;

endmodule

// File: rtl/tea_stream_gen.sv
// AXI-Stream master feeding pseudo-random 64-bit plaintext to the TEA chain,
// with a tap (textI/textI_vld) for the downstream comparison checker.
//   clk, resetn       : clock, asynchronous active-low reset
//   start             : begins a run when idle
//   busy, done        : run in progress / one-cycle end-of-run pulse
//   m_tdata/tvalid/tready/tlast : AXI-Stream master
//   textI, textI_vld  : checker tap, one strobe per accepted beat
//   count             : beats accepted in the current or last run
//
// state | meaning
// IDLE  | waiting for start
// SEND  | beat presented, waiting for handshake
// GAPW  | idle gap after an accepted beat
// FIN   | done pulse, then back to IDLE
module tea_stream_gen
    import tea_stream_pkg::*;
#(
    parameter int          NUM_WORDS = 128,
    parameter int          PKT_LEN   = 16,
    parameter int          GAP       = 0,
    parameter logic [63:0] SEED      = 64'h0123456789ABCDEF
)
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [63:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [63:0] textI,
    output logic        textI_vld,
    output logic [15:0] count
);

    localparam logic [63:0] SEED_EFF = (SEED == 64'h0) ? 64'h1 : SEED;
    localparam logic [15:0] LAST_IDX = 16'(NUM_WORDS - 1);
    localparam logic [15:0] PKT_LAST = 16'(PKT_LEN - 1);
    localparam logic [7:0]  GAP_LOAD = 8'((GAP > 0) ? (GAP - 1) : 0);

    state_t      r_state;
    logic [15:0] r_idx;
    logic [15:0] r_pkt_pos;
    logic [15:0] r_count;
    logic [7:0]  r_gap_cnt;
    logic        r_armed;
    logic        r_busy;
    logic        r_done;
    logic        r_tvalid;
    logic        r_tlast;

    logic        w_hs;
    logic        w_start_ok;
    logic [15:0] w_idx_nxt;
    logic [15:0] w_pos_nxt;
    logic [63:0] w_q;

    // r_tvalid is only ever set in SEND, so this is a handshake in SEND.
    assign w_hs       = r_tvalid & m_tready;
    // r_armed masks a start arriving on the first edge after reset release.
    assign w_start_ok = (r_state == ST_IDLE) & start & r_armed;
    assign w_idx_nxt  = r_idx + 16'd1;
    assign w_pos_nxt  = (r_pkt_pos == PKT_LAST) ? 16'd0 : r_pkt_pos + 16'd1;

    lfsr64 u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .load   (w_start_ok),
        .seed   (SEED_EFF),
        .step   (w_hs),
        .q      (w_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= ST_IDLE;
            r_idx     <= 16'd0;
            r_pkt_pos <= 16'd0;
            r_count   <= 16'd0;
            r_gap_cnt <= 8'd0;
            r_armed   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_tvalid  <= 1'b0;
            r_tlast   <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_state   <= ST_SEND;
                        r_busy    <= 1'b1;
                        r_tvalid  <= 1'b1;
                        r_count   <= 16'd0;
                        r_idx     <= 16'd0;
                        r_pkt_pos <= 16'd0;
                        r_tlast   <= (PKT_LAST == 16'd0) || (LAST_IDX == 16'd0);
                    end
                end
                ST_SEND: begin
                    if (w_hs) begin
                        r_count   <= r_count + 16'd1;
                        r_idx     <= w_idx_nxt;
                        r_pkt_pos <= w_pos_nxt;
                        if (r_idx == LAST_IDX) begin
                            r_state  <= ST_FIN;
                            r_tvalid <= 1'b0;
                            r_tlast  <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                        end else begin
                            // TLAST is precomputed for the beat presented next.
                            r_tlast <= (w_pos_nxt == PKT_LAST) || (w_idx_nxt == LAST_IDX);
                            if (GAP > 0) begin
                                r_state   <= ST_GAPW;
                                r_tvalid  <= 1'b0;
                                r_gap_cnt <= GAP_LOAD;
                            end
                        end
                    end
                end
                ST_GAPW: begin
                    if (r_gap_cnt == 8'd0) begin
                        r_state  <= ST_SEND;
                        r_tvalid <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                ST_FIN: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign m_tdata   = w_q;
    assign m_tvalid  = r_tvalid;
    assign m_tlast   = r_tlast;
    assign textI     = w_q;
    assign textI_vld = r_tvalid & m_tready;
    assign count     = r_count;

endmodule

// File: tb/tb_tea_stream_gen.sv
module tb_tea_stream_gen;

    logic             clk;
    logic             resetn;
    logic [3:0]       start_v;
    logic [3:0]       tready_v;
    logic [3:0]       busy_v, done_v, tvalid_v, tlast_v, tvld_v;
    logic [3:0][63:0] tdata_v, texti_v;
    logic [3:0][15:0] count_v;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: spec vectors   1: gapped short packet   2: SEED=0, odd packet   3: defaults
    tea_stream_gen #(.NUM_WORDS(4), .PKT_LEN(2), .GAP(0), .SEED(64'h1)) u_a (
        .clk(clk), .resetn(resetn), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .m_tdata(tdata_v[0]), .m_tvalid(tvalid_v[0]), .m_tready(tready_v[0]), .m_tlast(tlast_v[0]),
        .textI(texti_v[0]), .textI_vld(tvld_v[0]), .count(count_v[0]));

    tea_stream_gen #(.NUM_WORDS(3), .PKT_LEN(16), .GAP(2), .SEED(64'h1)) u_b (
        .clk(clk), .resetn(resetn), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .m_tdata(tdata_v[1]), .m_tvalid(tvalid_v[1]), .m_tready(tready_v[1]), .m_tlast(tlast_v[1]),
        .textI(texti_v[1]), .textI_vld(tvld_v[1]), .count(count_v[1]));

    tea_stream_gen #(.NUM_WORDS(37), .PKT_LEN(5), .GAP(1), .SEED(64'h0)) u_c (
        .clk(clk), .resetn(resetn), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .m_tdata(tdata_v[2]), .m_tvalid(tvalid_v[2]), .m_tready(tready_v[2]), .m_tlast(tlast_v[2]),
        .textI(texti_v[2]), .textI_vld(tvld_v[2]), .count(count_v[2]));

    tea_stream_gen u_d (
        .clk(clk), .resetn(resetn), .start(start_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .m_tdata(tdata_v[3]), .m_tvalid(tvalid_v[3]), .m_tready(tready_v[3]), .m_tlast(tlast_v[3]),
        .textI(texti_v[3]), .textI_vld(tvld_v[3]), .count(count_v[3]));

    typedef struct {
        logic [63:0] data;
        logic        last;
    } beat_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference sequence: the n-th plaintext is the seed shifted right n times,
    // folding the polynomial in whenever a 1 falls off the bottom.
    function automatic logic [63:0] ref_word(input logic [63:0] seed, input int n);
        logic [63:0] s;
        s = (seed == 64'h0) ? 64'h1 : seed;
        for (int i = 0; i < n; i++) begin
            if (s[0]) s = (s >> 1) ^ 64'hD800000000000000;
            else      s = s >> 1;
        end
        return s;
    endfunction

    function automatic logic ref_last(input int i, input int nw, input int pkt);
        return ((i % pkt) == pkt - 1) || (i == nw - 1);
    endfunction

    // Called at posedge+1 with instance k idle. mode: 0 always ready,
    // 1 random ready, 2 ready low for 3 cycles while beat 1 is valid.
    // mid_at >= 0 pulses start while that beat is pending.
    task automatic run_stream(input int k, input int nw, input int pkt, input int gap,
                              input logic [63:0] seed, input int mode, input int mid_at);
        int   beat, low, cyc, stall, budget;
        logic pend, sent_mid, rdy;
        beat = 0; low = 0; cyc = 0; stall = 0; pend = 1'b0; sent_mid = 1'b0;
        budget = nw * (gap + 1) * 8 + 50;
        start_v[k] = 1'b1;
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        while (beat < nw && cyc < budget) begin
            case (mode)
                1:       rdy = ($urandom_range(0, 2) != 0);
                2:       rdy = !(beat == 1 && stall < 3 && tvalid_v[k]);
                default: rdy = 1'b1;
            endcase
            if (!rdy) stall++;
            start_v[k] = (mid_at >= 0 && beat == mid_at && !sent_mid);
            if (start_v[k]) sent_mid = 1'b1;
            tready_v[k] = rdy;
            #1;
            chk("busy_run", busy_v[k], 1);
            chk("count_run", count_v[k], beat);
            chk("done_run", done_v[k], 0);
            if (tvalid_v[k]) begin
                if (pend) chk("gap_len", low, gap);
                pend = 1'b0;
                chk("tdata", tdata_v[k], ref_word(seed, beat));
                chk("tlast", tlast_v[k], ref_last(beat, nw, pkt));
                chk("textI", texti_v[k], tdata_v[k]);
                chk("textI_vld", tvld_v[k], rdy);
                if (rdy) begin
                    beat++;
                    pend = 1'b1;
                    low  = 0;
                end
            end else begin
                chk("textI_vld_idle", tvld_v[k], 0);
                low++;
            end
            @(posedge clk); #1;
            start_v[k] = 1'b0;
            cyc++;
        end
        if (beat < nw) begin
            checks++; errors++;
            $display("FAIL run_timeout: got %0d beats expected %0d", beat, nw);
        end
        if (mode == 2) chk("stall_cycles", stall, 3);
        tready_v[k] = 1'b0;
        start_v[k]  = 1'b1;   // start during FIN must be ignored
        #1;
        chk("done_pulse", done_v[k], 1);
        chk("busy_fin", busy_v[k], 0);
        chk("count_final", count_v[k], nw);
        chk("tvalid_fin", tvalid_v[k], 0);
        @(posedge clk); #1;
        start_v[k] = 1'b0;
        chk("done_clear", done_v[k], 0);
        chk("count_hold", count_v[k], nw);
        @(posedge clk); #1;
        chk("idle_tvalid", tvalid_v[k], 0);
        chk("idle_busy", busy_v[k], 0);
    endtask

    initial begin
        beat_t vec[4];
        vec[0] = '{64'h0000000000000001, 1'b0};
        vec[1] = '{64'hD800000000000000, 1'b1};
        vec[2] = '{64'h6C00000000000000, 1'b0};
        vec[3] = '{64'h3600000000000000, 1'b1};

        resetn   = 1'b0;
        start_v  = '0;
        tready_v = '0;

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_busy", busy_v[k], 0);
            chk("rst_done", done_v[k], 0);
            chk("rst_tvalid", tvalid_v[k], 0);
            chk("rst_tlast", tlast_v[k], 0);
            chk("rst_tdata", tdata_v[k], 0);
            chk("rst_textI", texti_v[k], 0);
            chk("rst_textI_vld", tvld_v[k], 0);
            chk("rst_count", count_v[k], 0);
        end
        resetn     = 1'b1;
        start_v[0] = 1'b1;    // coincides with reset release: ignored
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            chk("post_rst_tvalid", tvalid_v[0], 0);
            chk("post_rst_busy", busy_v[0], 0);
            @(posedge clk); #1;
        end

        // Spec vectors, full rate
        tready_v[0] = 1'b1;
        start_v[0]  = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("vec_tvalid", tvalid_v[0], 1);
            chk("vec_tdata", tdata_v[0], vec[i].data);
            chk("vec_tlast", tlast_v[0], vec[i].last);
            chk("vec_textI_vld", tvld_v[0], 1);
            @(posedge clk); #1;
        end
        chk("vec_done", done_v[0], 1);
        chk("vec_busy", busy_v[0], 0);
        chk("vec_count", count_v[0], 4);
        chk("vec_tvalid_end", tvalid_v[0], 0);
        tready_v[0] = 1'b0;
        @(posedge clk); #1;
        chk("vec_done_once", done_v[0], 0);

        // Backpressure on beat 1, then mid-run start, then repeat run from SEED
        run_stream(0, 4, 2, 0, 64'h1, 2, -1);
        run_stream(0, 4, 2, 0, 64'h1, 0, 2);
        run_stream(0, 4, 2, 0, 64'h1, 1, 1);

        // Gap of 2 cycles, short final packet
        run_stream(1, 3, 16, 2, 64'h1, 0, -1);
        run_stream(1, 3, 16, 2, 64'h1, 1, 1);

        // Reset during beat 2
        tready_v[0] = 1'b1;
        start_v[0]  = 1'b1;
        @(posedge clk); #1;
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_tdata", tdata_v[0], 64'h6C00000000000000);
        resetn = 1'b0;
        #1;
        chk("async_tvalid", tvalid_v[0], 0);
        chk("async_tdata", tdata_v[0], 0);
        chk("async_busy", busy_v[0], 0);
        chk("async_count", count_v[0], 0);
        chk("async_textI_vld", tvld_v[0], 0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        run_stream(0, 4, 2, 0, 64'h1, 0, -1);

        // Randomized longer runs against the reference sequence
        run_stream(2, 37, 5, 1, 64'h0, 1, 7);
        run_stream(3, 128, 16, 0, 64'h0123456789ABCDEF, 1, 50);
        run_stream(3, 128, 16, 0, 64'h0123456789ABCDEF, 0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
